// File: rtl/fft_in_reorder8.sv
// Ping-pong input staging buffer for the 8-point FFT: serial complex samples are scattered
// into bit-reversed slots and each completed frame is presented as one parallel vector.
module fft_in_reorder8 #(
  parameter int unsigned DATA_WD = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 dat_val_i,
  output logic                 dat_rdy_o,
  input  logic                 dat_sof_i,
  input  logic [DATA_WD-1:0]   dat_re_i,
  input  logic [DATA_WD-1:0]   dat_im_i,
  output logic                 vec_val_o,
  input  logic                 vec_rdy_i,
  output logic [8*DATA_WD-1:0] vec_re_o,
  output logic [8*DATA_WD-1:0] vec_im_o,
  output logic                 drop_o
);

  typedef logic [DATA_WD-1:0] samp_t;

  samp_t       bank_re_q [2][8];
  samp_t       bank_re_d [2][8];
  samp_t       bank_im_q [2][8];
  samp_t       bank_im_d [2][8];
  logic [1:0]  full_q, full_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [2:0]  wr_cnt_q, wr_cnt_d;
  logic        drop_q, drop_d;

  logic        accept;
  logic        consume;
  logic [2:0]  idx;

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  assign dat_rdy_o = ~full_q[wr_bank_q];
  assign vec_val_o = full_q[rd_bank_q];
  assign drop_o    = drop_q;

  always_comb begin
    accept    = dat_val_i & dat_rdy_o;
    consume   = vec_val_o & vec_rdy_i;
    // A start-of-frame sample always lands at index 0, whatever the running count says.
    idx       = dat_sof_i ? 3'd0 : wr_cnt_q;
    bank_re_d = bank_re_q;
    bank_im_d = bank_im_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    drop_d    = accept & dat_sof_i & (wr_cnt_q != 3'd0);

    if (accept) begin
      bank_re_d[wr_bank_q][bitrev3(idx)] = dat_re_i;
      bank_im_d[wr_bank_q][bitrev3(idx)] = dat_im_i;
      wr_cnt_d = idx + 3'd1;
      if (idx == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // Completion targets an empty bank and consume a full one, so they never collide.
    if (consume) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_comb begin
    vec_re_o = '0;
    vec_im_o = '0;
    for (int k = 0; k < 8; k++) begin
      vec_re_o[(7-k)*DATA_WD +: DATA_WD] = bank_re_q[rd_bank_q][k];
      vec_im_o[(7-k)*DATA_WD +: DATA_WD] = bank_im_q[rd_bank_q][k];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          bank_re_q[b][k] <= '0;
          bank_im_q[b][k] <= '0;
        end
      end
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= 3'd0;
      drop_q    <= 1'b0;
    end else begin
      bank_re_q <= bank_re_d;
      bank_im_q <= bank_im_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_fft_in_reorder8.sv
// Self-checking bench for fft_in_reorder8: directed scenarios plus a random soak against a
// frame-level scoreboard model.
module tb_fft_in_reorder8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic           dat_val, dat_sof, vec_rdy;
  logic [W-1:0]   dat_re, dat_im;
  logic           dat_rdy, vec_val, drop;
  logic [8*W-1:0] vec_re, vec_im;

  int checks = 0;
  int errors = 0;
  int order[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  // Frame-level reference model
  logic [W-1:0]   m_re[8];
  logic [W-1:0]   m_im[8];
  int             m_cnt;
  bit             m_drop;
  logic [8*W-1:0] q_re[$];
  logic [8*W-1:0] q_im[$];

  fft_in_reorder8 #(.DATA_WD(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .dat_val_i(dat_val),
    .dat_rdy_o(dat_rdy),
    .dat_sof_i(dat_sof),
    .dat_re_i (dat_re),
    .dat_im_i (dat_im),
    .vec_val_o(vec_val),
    .vec_rdy_i(vec_rdy),
    .vec_re_o (vec_re),
    .vec_im_o (vec_im),
    .drop_o   (drop)
  );

  always #5 clk = ~clk;

  // Expected vector: slot k holds (base + order[k]), optionally negated.
  function automatic logic [8*W-1:0] pack_vec(input int base, input bit neg);
    logic [8*W-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      v = base + order[k];
      if (neg) v = -v;
      r[(7-k)*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  task automatic drive(input bit val, input bit sof, input int re, input int im, input bit vr);
    dat_val = val;
    dat_sof = sof;
    dat_re  = re[W-1:0];
    dat_im  = im[W-1:0];
    vec_rdy = vr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_drop = 0;
    q_re.delete();
    q_im.delete();
  endtask

  // Applies one clock edge worth of the current inputs to the model.
  task automatic model_edge();
    bit acc, cons;
    int rv;
    logic [8*W-1:0] vr, vi;
    acc    = dat_val && (q_re.size() < 2);
    cons   = (q_re.size() > 0) && vec_rdy;
    m_drop = 0;
    if (cons) begin
      void'(q_re.pop_front());
      void'(q_im.pop_front());
    end
    if (acc) begin
      if (dat_sof) begin
        if (m_cnt != 0) m_drop = 1;
        m_cnt = 0;
      end
      m_re[m_cnt] = dat_re;
      m_im[m_cnt] = dat_im;
      m_cnt++;
      if (m_cnt == 8) begin
        vr = '0;
        vi = '0;
        for (int n = 0; n < 8; n++) begin
          rv = ((n % 2) * 4) + (((n / 2) % 2) * 2) + ((n / 4) % 2);
          vr[(7-rv)*W +: W] = m_re[n];
          vi[(7-rv)*W +: W] = m_im[n];
        end
        q_re.push_back(vr);
        q_im.push_back(vi);
        m_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++; if (vec_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b exp 0", vec_val); end
    checks++; if (dat_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b exp 1", dat_rdy); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b exp 0", drop); end
    checks++; if (vec_re !== '0) begin errors++; $display("FAIL reset_re: got %h exp 0", vec_re); end
    checks++; if (vec_im !== '0) begin errors++; $display("FAIL reset_im: got %h exp 0", vec_im); end
  endtask

  task automatic test_bitrev();
    do_reset();
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (vec_val !== 1'b0) begin errors++; $display("FAIL bitrev_early_val n=%0d: got %b exp 0", n, vec_val); end
      drive(1, n == 0, n, -n, 1);
      tick();
    end
    checks++; if (vec_val !== 1'b1) begin errors++; $display("FAIL bitrev_val: got %b exp 1", vec_val); end
    checks++;
    if (vec_re !== pack_vec(0, 0)) begin errors++; $display("FAIL bitrev_re: got %h exp %h", vec_re, pack_vec(0, 0)); end
    checks++;
    if (vec_im !== pack_vec(0, 1)) begin errors++; $display("FAIL bitrev_im: got %h exp %h", vec_im, pack_vec(0, 1)); end
    drive(0, 0, 0, 0, 1);
    tick();
    checks++; if (vec_val !== 1'b0) begin errors++; $display("FAIL bitrev_one_cycle: got %b exp 0", vec_val); end
  endtask

  task automatic test_streaming();
    int nvec, last;
    do_reset();
    nvec = 0;
    last = 0;
    for (int i = 0; i <= 64; i++) begin
      checks++; if (dat_rdy !== 1'b1) begin errors++; $display("FAIL stream_rdy i=%0d: got %b exp 1", i, dat_rdy); end
      if (vec_val === 1'b1) begin
        checks++;
        if (vec_re !== pack_vec(8 * nvec, 0)) begin
          errors++; $display("FAIL stream_re v=%0d: got %h exp %h", nvec, vec_re, pack_vec(8 * nvec, 0));
        end
        checks++;
        if ((nvec == 0 && i != 8) || (nvec > 0 && i - last != 8)) begin
          errors++; $display("FAIL stream_spacing v=%0d: got cycle %0d prev %0d exp step 8", nvec, i, last);
        end
        last = i;
        nvec++;
      end
      drive(i < 64, (i % 8) == 0, i, 0, 1);
      tick();
    end
    checks++; if (nvec != 8) begin errors++; $display("FAIL stream_count: got %0d exp 8", nvec); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (dat_rdy !== (c < 16)) begin errors++; $display("FAIL bp_rdy c=%0d: got %b exp %b", c, dat_rdy, c < 16); end
      drive(1, (c % 8) == 0 && c < 16, (c < 16) ? c : 999, 0, 0);
      tick();
    end
    checks++; if (vec_val !== 1'b1) begin errors++; $display("FAIL bp_val0: got %b exp 1", vec_val); end
    checks++;
    if (vec_re !== pack_vec(0, 0)) begin errors++; $display("FAIL bp_frame0: got %h exp %h", vec_re, pack_vec(0, 0)); end
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    checks++; if (dat_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_back: got %b exp 1", dat_rdy); end
    checks++; if (vec_val !== 1'b1) begin errors++; $display("FAIL bp_val1: got %b exp 1", vec_val); end
    checks++;
    if (vec_re !== pack_vec(8, 0)) begin errors++; $display("FAIL bp_frame1: got %h exp %h", vec_re, pack_vec(8, 0)); end
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    checks++; if (vec_val !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", vec_val); end
  endtask

  task automatic test_resync();
    int seq[11] = '{100, 101, 102, 0, 1, 2, 3, 4, 5, 6, 7};
    int drops;
    do_reset();
    drops = 0;
    for (int i = 0; i <= 12; i++) begin
      if (drop === 1'b1) drops++;
      if (i == 4) begin
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL resync_drop_pulse: got %b exp 1", drop); end
      end
      if (i == 11) begin
        checks++; if (vec_val !== 1'b1) begin errors++; $display("FAIL resync_val: got %b exp 1", vec_val); end
        checks++;
        if (vec_re !== pack_vec(0, 0)) begin
          errors++; $display("FAIL resync_re: got %h exp %h", vec_re, pack_vec(0, 0));
        end
      end
      if (i < 11) drive(1, i == 0 || i == 3, seq[i], 0, 1);
      else drive(0, 0, 0, 0, 1);
      tick();
    end
    checks++; if (drops != 1) begin errors++; $display("FAIL resync_drop_count: got %0d exp 1", drops); end
  endtask

  task automatic test_midreset();
    int nvec;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(1, i == 0 || i == 8, (i < 8) ? 50 + i : i - 8, 7, 0);
      tick();
    end
    checks++; if (vec_val !== 1'b1) begin errors++; $display("FAIL mr_pending: got %b exp 1", vec_val); end
    drive(0, 0, 0, 0, 0);
    #1 rstn = 1'b0;
    #1;
    checks++; if (vec_val !== 1'b0) begin errors++; $display("FAIL mr_val: got %b exp 0", vec_val); end
    checks++; if (vec_re !== '0) begin errors++; $display("FAIL mr_re: got %h exp 0", vec_re); end
    checks++; if (vec_im !== '0) begin errors++; $display("FAIL mr_im: got %h exp 0", vec_im); end
    checks++; if (dat_rdy !== 1'b1) begin errors++; $display("FAIL mr_rdy: got %b exp 1", dat_rdy); end
    @(negedge clk);
    rstn = 1'b1;
    nvec = 0;
    for (int i = 0; i < 12; i++) begin
      if (vec_val === 1'b1) begin
        nvec++;
        checks++;
        if (vec_re !== pack_vec(20, 0)) begin
          errors++; $display("FAIL mr_frame: got %h exp %h", vec_re, pack_vec(20, 0));
        end
      end
      if (i < 8) drive(1, i == 0, 20 + i, 0, 1);
      else drive(0, 0, 0, 0, 1);
      tick();
    end
    checks++; if (nvec != 1) begin errors++; $display("FAIL mr_count: got %0d exp 1", nvec); end
  endtask

  task automatic test_random();
    bit ev;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ev = q_re.size() > 0;
      checks++;
      if (dat_rdy !== (q_re.size() < 2)) begin
        errors++; $display("FAIL rnd_rdy c=%0d: got %b exp %b", c, dat_rdy, q_re.size() < 2);
      end
      checks++;
      if (vec_val !== ev) begin errors++; $display("FAIL rnd_val c=%0d: got %b exp %b", c, vec_val, ev); end
      checks++;
      if (drop !== m_drop) begin errors++; $display("FAIL rnd_drop c=%0d: got %b exp %b", c, drop, m_drop); end
      if (ev) begin
        checks++;
        if (vec_re !== q_re[0] || vec_im !== q_im[0]) begin
          errors++;
          $display("FAIL rnd_vec c=%0d: got %h/%h exp %h/%h", c, vec_re, vec_im, q_re[0], q_im[0]);
        end
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, int'($urandom), int'($urandom),
            $urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 7 : 2));
      model_edge();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_bitrev();
    test_streaming();
    test_backpressure();
    test_resync();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
